// File: rtl/uart_fifo_param_pkg.sv
// uart_fifo_param_pkg
// Shared defaults for the UART FIFO slice. The macros UART_FIFO_WIDTH,
// UART_FIFO_DEPTH, UART_FIFO_POINTER_W and UART_FIFO_COUNTER_W normally come
// from the project-wide uart_defines.v. They are given fallback values here
// so that this slice builds on its own. UART_FIFO_LEVEL_EN (optional level
// comparator) is deliberately left undefined here; define it on the command
// line or in uart_defines.v to enable lvl_hit.
// No ports: package only.
`ifndef UART_FIFO_WIDTH
`define UART_FIFO_WIDTH 8
`endif
`ifndef UART_FIFO_DEPTH
`define UART_FIFO_DEPTH 16
`endif
`ifndef UART_FIFO_POINTER_W
`define UART_FIFO_POINTER_W 4
`endif
`ifndef UART_FIFO_COUNTER_W
`define UART_FIFO_COUNTER_W 5
`endif

package uart_fifo_param_pkg;
  localparam int DEF_FIFO_WIDTH = `UART_FIFO_WIDTH;
  localparam int DEF_FIFO_DEPTH = `UART_FIFO_DEPTH;
  localparam int DEF_FIFO_PTR_W = `UART_FIFO_POINTER_W;
  localparam int DEF_FIFO_CNT_W = `UART_FIFO_COUNTER_W;

  // Decoded per-edge operation, handy for binding checkers.
  typedef struct packed {
    logic do_push;   // write accepted this edge
    logic do_pop;    // read accepted this edge
    logic ovr_evt;   // push dropped because the FIFO was full
  } fifo_op_t;
endpackage

// File: rtl/uart_fifo_ram.sv
// uart_fifo_ram
// Storage array for the UART FIFO: synchronous write, asynchronous read,
// no reset (contents survive reset and flush).
// Ports:
//   clk   - rising-edge clock
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - read address
//   rdata - read data (combinational from raddr)
module uart_fifo_ram #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/uart_fifo_param.sv
// uart_fifo_param
// Parametrised show-ahead FIFO for the UART data paths, with a sticky
// overrun flag and an optional occupancy level trigger.
// Optional feature: define UART_FIFO_LEVEL_EN to enable the registered
// lvl_hit comparator; otherwise lvl_hit is tied to 0 and level is ignored.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   push      - write strobe, data_in is written when accepted
//   pop       - read strobe, advances past data_out when accepted
//   flush     - discard all contents (priority over push/pop)
//   clr_ovr   - clear sticky overrun
//   data_in   - write data
//   level     - lvl_hit threshold
//   data_out  - head-of-queue data (undefined while empty)
//   count     - occupancy; empty/full derived from it
//   overrun   - sticky: set when a push is dropped
//   lvl_hit   - registered count>=level (feature enabled only)
//
// Handshake: push and pop are single-cycle strobes with no ready return.
// A push is accepted when full=0, or when full=1 together with a pop.
// A pop is accepted when empty=0. Rejected pushes set overrun; rejected
// pops are silently ignored. Flags reflect the edge just taken.
module uart_fifo_param
  import uart_fifo_param_pkg::*;
#(
  parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int FIFO_PTR_W = DEF_FIFO_PTR_W,
  parameter int FIFO_CNT_W = DEF_FIFO_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic                  clr_ovr,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic [FIFO_CNT_W-1:0] level,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic [FIFO_CNT_W-1:0] count,
  output logic                  empty,
  output logic                  full,
  output logic                  overrun,
  output logic                  lvl_hit
);
  localparam logic [FIFO_CNT_W-1:0] DEPTH_C = FIFO_CNT_W'(FIFO_DEPTH);
  localparam logic [FIFO_CNT_W-1:0] CNT_ONE = FIFO_CNT_W'(1);
  localparam logic [FIFO_PTR_W-1:0] PTR_ONE = FIFO_PTR_W'(1);

  logic [FIFO_PTR_W-1:0] wr_ptr, rd_ptr;
  logic [FIFO_CNT_W-1:0] cnt_q, cnt_next;
  logic                  ovr_q;
  logic                  is_full, is_empty;
  logic                  ram_we;
  fifo_op_t              op;

  always_comb begin
    is_full    = (cnt_q == DEPTH_C);
    is_empty   = (cnt_q == '0);
    op.do_pop  = pop && !is_empty;
    // When full, a concurrent pop frees the slot this push lands in.
    op.do_push = push && (!is_full || pop);
    op.ovr_evt = push && is_full && !pop;

    cnt_next = cnt_q;
    if (flush) begin
      cnt_next = '0;
    end else begin
      case ({op.do_push, op.do_pop})
        2'b10:   cnt_next = cnt_q + CNT_ONE;
        2'b01:   cnt_next = cnt_q - CNT_ONE;
        default: cnt_next = cnt_q;
      endcase
    end

    ram_we = op.do_push && !flush && !rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      ovr_q  <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        // Pointers wrap by natural overflow (depth is a power of two).
        if (op.do_push) wr_ptr <= wr_ptr + PTR_ONE;
        if (op.do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
      cnt_q <= cnt_next;
      // Set beats clear; a flush edge does not count as an overrun event.
      if (op.ovr_evt && !flush) ovr_q <= 1'b1;
      else if (clr_ovr)         ovr_q <= 1'b0;
    end
  end

  uart_fifo_ram #(
    .WIDTH  (FIFO_WIDTH),
    .DEPTH  (FIFO_DEPTH),
    .ADDR_W (FIFO_PTR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr),
    .wdata (data_in),
    .raddr (rd_ptr),
    .rdata (data_out)
  );

`ifdef UART_FIFO_LEVEL_EN
  logic lvl_q;
  always_ff @(posedge clk) begin
    if (rst) lvl_q <= 1'b0;
    else     lvl_q <= (cnt_next >= level);
  end
  assign lvl_hit = lvl_q;
`else
  logic unused_level;
  assign unused_level = ^level;
  assign lvl_hit      = 1'b0;
`endif

  assign count   = cnt_q;
  assign empty   = is_empty;
  assign full    = is_full;
  assign overrun = ovr_q;
endmodule

// File: tb/tb_uart_fifo_param.sv
module tb_uart_fifo_param;
  localparam int W     = 8;
  localparam int DEPTH = 16;
  localparam int CW    = 5;

  logic          clk = 1'b0;
  logic          rst, push, pop, flush, clr_ovr;
  logic [W-1:0]  data_in;
  logic [CW-1:0] level;
  logic [W-1:0]  data_out;
  logic [CW-1:0] count;
  logic          empty, full, overrun, lvl_hit;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of stored words plus flag state.
  logic [W-1:0] exp_q[$];
  logic         exp_ovr;
  logic         exp_lvl;

  uart_fifo_param dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .flush(flush),
    .clr_ovr(clr_ovr), .data_in(data_in), .level(level),
    .data_out(data_out), .count(count), .empty(empty), .full(full),
    .overrun(overrun), .lvl_hit(lvl_hit)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  function automatic logic level_expect(int n);
`ifdef UART_FIFO_LEVEL_EN
    return (n >= int'(level));
`else
    return 1'b0;
`endif
  endfunction

  // ---------------- driver ----------------
  // Applies one edge of stimulus, advances the model, returns #1 after edge.
  task automatic drive(input logic p, input logic po, input logic f,
                       input logic c, input logic [W-1:0] d);
    logic was_full;
    push = p; pop = po; flush = f; clr_ovr = c; data_in = d;
    @(posedge clk);
    if (f) begin
      exp_q.delete();
    end else begin
      was_full = (exp_q.size() == DEPTH);
      if (po && exp_q.size() > 0) void'(exp_q.pop_front());
      if (p && exp_q.size() < DEPTH) exp_q.push_back(d);
      if (p && was_full && !po) exp_ovr = 1'b1;
      else if (c) exp_ovr = 1'b0;
    end
    if (f && c) exp_ovr = 1'b0;
    exp_lvl = level_expect(exp_q.size());
    #1;
    push = 0; pop = 0; flush = 0; clr_ovr = 0;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    exp_ovr = 1'b0;
    exp_lvl = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset(2);
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", overrun); end
    checks++; if (lvl_hit !== 1'b0) begin errors++; $display("FAIL reset_lvl_hit got %b exp 0", lvl_hit); end
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= DEPTH; i++) drive(1, 0, 0, 0, W'(i));
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full got %b exp 1", full); end
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL fill_count got %0d exp 16", count); end
    for (int i = 1; i <= DEPTH; i++) begin
      checks++;
      if (data_out !== W'(i)) begin errors++; $display("FAIL drain_data[%0d] got %h exp %h", i, data_out, W'(i)); end
      drive(0, 1, 0, 0, '0);
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %b exp 1", empty); end
    drive(0, 1, 0, 0, '0);  // pop on empty is ignored
    checks++; if (count !== 5'd0 || overrun !== 1'b0) begin
      errors++; $display("FAIL empty_pop got count %0d ovr %b exp 0 0", count, overrun); end
  endtask

  task automatic test_overrun();
    for (int i = 1; i <= DEPTH; i++) drive(1, 0, 0, 0, W'(i));
    drive(1, 0, 0, 0, 8'hAA);
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL ovr_count got %0d exp 16", count); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got %b exp 1", overrun); end
    checks++; if (data_out !== 8'h01) begin errors++; $display("FAIL ovr_head got %h exp 01", data_out); end
    drive(1, 0, 0, 1, 8'hBB);  // set wins over clear on the same edge
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set_wins got %b exp 1", overrun); end
    drive(0, 0, 0, 1, '0);
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear got %b exp 0", overrun); end
    drive(0, 0, 1, 0, '0);
  endtask

  task automatic test_simultaneous();
    drive(1, 1, 0, 0, 8'h5A);
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL simul_empty_count got %0d exp 1", count); end
    checks++; if (data_out !== 8'h5A) begin errors++; $display("FAIL simul_empty_data got %h exp 5a", data_out); end
    for (int i = 0; i < DEPTH - 1; i++) drive(1, 0, 0, 0, W'($urandom_range(0, 255)));
    drive(1, 1, 0, 0, 8'hC3);
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL simul_full_count got %0d exp 16", count); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL simul_full_ovr got %b exp 0", overrun); end
    checks++; if (data_out !== exp_q[0]) begin errors++; $display("FAIL simul_full_head got %h exp %h", data_out, exp_q[0]); end
    drive(0, 0, 1, 0, '0);
  endtask

  task automatic test_wrap_flush();
    for (int i = 0; i < 6; i++) drive(1, 0, 0, 0, W'($urandom_range(0, 255)));
    for (int i = 0; i < 40; i++) begin
      drive(1, 1, 0, 0, W'($urandom_range(0, 255)));
      checks++;
      if (data_out !== exp_q[0] || count !== CW'(exp_q.size())) begin
        errors++; $display("FAIL wrap[%0d] got data %h count %0d exp %h %0d",
                           i, data_out, count, exp_q[0], exp_q.size()); end
    end
    drive(1, 0, 1, 0, 8'h77);
    checks++; if (count !== 5'd0 || empty !== 1'b1) begin
      errors++; $display("FAIL flush got count %0d empty %b exp 0 1", count, empty); end
  endtask

  task automatic test_level();
    level = 5'd8;
    for (int i = 1; i <= 9; i++) begin
      drive(1, 0, 0, 0, W'(i));
      checks++;
      if (lvl_hit !== level_expect(i)) begin
        errors++; $display("FAIL lvl_rise[%0d] got %b exp %b", i, lvl_hit, level_expect(i)); end
    end
    for (int i = 8; i >= 6; i--) begin
      drive(0, 1, 0, 0, '0);
      checks++;
      if (lvl_hit !== level_expect(i)) begin
        errors++; $display("FAIL lvl_fall[%0d] got %b exp %b", i, lvl_hit, level_expect(i)); end
    end
    drive(0, 0, 1, 0, '0);
  endtask

  task automatic test_random();
    logic p, po, f, c;
    for (int i = 0; i < 400; i++) begin
      p  = ($urandom_range(0, 99) < 60);
      po = ($urandom_range(0, 99) < 45);
      f  = ($urandom_range(0, 99) < 2);
      c  = ($urandom_range(0, 99) < 5);
      if (i % 50 == 0) level = CW'($urandom_range(0, DEPTH));
      drive(p, po, f, c, W'($urandom()));
      checks++;
      if (count !== CW'(exp_q.size()) || empty !== (exp_q.size() == 0) ||
          full !== (exp_q.size() == DEPTH) || overrun !== exp_ovr || lvl_hit !== exp_lvl) begin
        errors++; $display("FAIL rand_flags[%0d] got cnt %0d e %b f %b o %b l %b exp cnt %0d o %b l %b",
                           i, count, empty, full, overrun, lvl_hit, exp_q.size(), exp_ovr, exp_lvl); end
      if (exp_q.size() > 0) begin
        checks++;
        if (data_out !== exp_q[0]) begin
          errors++; $display("FAIL rand_data[%0d] got %h exp %h", i, data_out, exp_q[0]); end
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst = 1'b1; push = 0; pop = 0; flush = 0; clr_ovr = 0;
    data_in = '0; level = 5'd8;
    exp_ovr = 1'b0; exp_lvl = 1'b0;
    test_reset();
    test_fill_drain();
    test_overrun();
    test_simultaneous();
    test_wrap_flush();
    test_level();
    test_random();
    do_reset(2);
    checks++; if (count !== 5'd0 || overrun !== 1'b0 || lvl_hit !== 1'b0) begin
      errors++; $display("FAIL final_reset got cnt %0d o %b l %b", count, overrun, lvl_hit); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
